// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue unit: ALUctl codes, ALUOp/funct encodings,
// the response entry layout, the ALUOp/funct decoder and the reference ALU function.
package alu_issue_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Widest tag a response entry can carry; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [31:0]          result;
    logic                 zero;
    logic                 err;
    logic [TAG_MAX_W-1:0] tag;
  } resp_entry_t;

  typedef struct packed {
    logic [3:0] ctl;
    logic       err;
  } dec_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

  function automatic dec_t decode(input logic [1:0] aluop, input logic [5:0] funct);
    dec_t d;
    d.ctl = CTL_ADD;
    d.err = 1'b0;
    case (aluop)
      OP_ADD: d.ctl = CTL_ADD;
      OP_SUB: d.ctl = CTL_SUB;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  d.ctl = CTL_ADD;
          FN_SUB:  d.ctl = CTL_SUB;
          FN_AND:  d.ctl = CTL_AND;
          FN_OR:   d.ctl = CTL_OR;
          FN_SLT:  d.ctl = CTL_SLT;
          FN_NOR:  d.ctl = CTL_NOR;
          default: d.err = 1'b1;
        endcase
      end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (ctl)
      CTL_AND: r = a & b;
      CTL_OR:  r = a | b;
      CTL_ADD: r = a + b;
      CTL_SUB: r = a - b;
      CTL_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      CTL_NOR: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Synchronous FIFO of response entries with occupancy count and full/empty flags.
module alu_resp_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  resp_entry_t   wr_data_i,
  input  logic          pop_i,
  output resp_entry_t   rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  resp_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entries are cleared on reset so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/alu_issue_unit.sv
// Request-side driver for the MIPS ALU: decodes ALUOp/funct, drives the ALU for one
// cycle and returns tagged results through a response FIFO. Optional: ALU_ISSUE_SELFCHECK_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       ALUctl,
  output logic [31:0]      A,
  output logic [31:0]      B,
  input  logic [31:0]      ALUOut,
  input  logic             Zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [TAG_W-1:0] resp_tag,
  output logic             chk_fail
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic             issue_v;
  logic [3:0]       ctl_q;
  logic [31:0]      a_q, b_q;
  logic             err_q;
  logic [TAG_W-1:0] tag_q;
  dec_t             dec;

  logic             xfer, pop, push;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  resp_entry_t      push_entry, head;
  logic             unused_tag_hi;

  assign dec  = decode(req_aluop, req_funct);
  assign xfer = req_valid && req_ready;
  assign pop  = resp_valid && resp_ready;
  assign push = issue_v;

  // A popping slot can be reused by a request accepted on the same edge.
  assign req_ready = ((int'(issue_v) + int'(fifo_count)) < DEPTH) || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = xfer ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = xfer ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_v = (state_q == ST_ISSUE);
  end

  // Issue register; holds its contents while idle so the ALU inputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      err_q <= 1'b0;
      tag_q <= '0;
    end else if (xfer) begin
      ctl_q <= dec.ctl;
      a_q   <= req_a;
      b_q   <= req_b;
      err_q <= dec.err;
      tag_q <= req_tag;
    end
  end

  assign ALUctl = ctl_q;
  assign A      = a_q;
  assign B      = b_q;

  always_comb begin
    push_entry              = '0;
    push_entry.result       = err_q ? 32'd0 : ALUOut;
    push_entry.zero         = err_q ? 1'b0 : Zero;
    push_entry.err          = err_q;
    push_entry.tag[TAG_W-1:0] = tag_q;
  end

  alu_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (push_entry),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign resp_valid    = !fifo_empty;
  assign resp_result   = head.result;
  assign resp_zero     = head.zero;
  assign resp_err      = head.err;
  assign resp_tag      = head.tag[TAG_W-1:0];
  assign unused_tag_hi = ^head.tag;

`ifdef ALU_ISSUE_SELFCHECK_EN
  logic        chk_q;
  logic [31:0] ref_res;

  assign ref_res = alu_ref(ctl_q, a_q, b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 1'b0;
    else if (issue_v && !err_q && ((ALUOut != ref_res) || (Zero != (ref_res == 32'd0))))
      chk_q <= 1'b1;
  end

  assign chk_fail = chk_q;
`else
  assign chk_fail = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && fifo_empty));

endmodule
